// File: rtl/note_lane_engine.sv
// Note-track engine: N falling-note lanes fed from pattern RAM, per-tick hit judging,
// saturating BCD score, streak counter and an IDLE/RUN/PAUSE/DONE controller.
module note_lane_engine #(
  parameter int NUM_TRACKS   = 4,
  parameter int PATTERN_BITS = 4,
  parameter int FALL_DEPTH   = 4,
  parameter int ADDR_W       = 7,
  parameter int SCORE_DIGITS = 4
) (
  input  logic                               CLOCK_50,
  input  logic                               reset_n,
  input  logic                               tick,
  input  logic                               start,
  input  logic                               pause,
  input  logic [ADDR_W-1:0]                  end_addr,
  input  logic [NUM_TRACKS-1:0]              key_n,
  output logic [ADDR_W-1:0]                  pat_addr,
  input  logic [NUM_TRACKS*PATTERN_BITS-1:0] pat_data,
  output logic [NUM_TRACKS-1:0]              lane_bot,
  output logic [4*SCORE_DIGITS-1:0]          score_bcd,
  output logic [7:0]                         streak,
  output logic                               hit,
  output logic                               miss,
  output logic [1:0]                         state
);

  localparam int PH_W = (PATTERN_BITS > 1) ? $clog2(PATTERN_BITS) : 1;
  localparam int DR_W = $clog2(FALL_DEPTH + PATTERN_BITS + 1);
  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(PATTERN_BITS - 1);
  localparam logic [DR_W-1:0] DRAIN_STEPS = DR_W'(FALL_DEPTH + PATTERN_BITS);
  localparam logic [4*SCORE_DIGITS-1:0] ALL_NINES = {SCORE_DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t cur_state, nxt_state;

  logic [NUM_TRACKS-1:0]   key_meta, key_sync, press;
  logic                    pause_q, pause_rise;
  logic                    clear_run, step, load_now, draining, drain_last;
  logic [PH_W-1:0]         phase;
  logic [DR_W-1:0]         drain_cnt;
  logic [PATTERN_BITS-1:0] load_reg [NUM_TRACKS];
  logic [FALL_DEPTH-1:0]   fall_reg [NUM_TRACKS];

  function automatic logic [4*SCORE_DIGITS-1:0] bcd_inc(input logic [4*SCORE_DIGITS-1:0] v);
    logic [4*SCORE_DIGITS-1:0] r;
    logic                      carry;
    r     = v;
    carry = 1'b1;
    if (v != ALL_NINES) begin
      for (int i = 0; i < SCORE_DIGITS; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Buttons are asynchronous; press is the synchronised, inverted level.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      key_meta <= '1;
      key_sync <= '1;
      pause_q  <= 1'b0;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
      pause_q  <= pause;
    end
  end

  assign press      = ~key_sync;
  assign pause_rise = pause & ~pause_q;
  assign step       = tick & (cur_state == RUN) & ~pause_rise;
  assign load_now   = step & (phase == LAST_PHASE) & ~draining;
  assign drain_last = step & draining & (drain_cnt == DR_W'(1));
  assign state      = cur_state;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) cur_state <= IDLE;
    else          cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    clear_run = 1'b0;
    case (cur_state)
      IDLE, DONE: begin
        if (start) begin
          nxt_state = RUN;
          clear_run = 1'b1;
        end
      end
      RUN: begin
        if (pause_rise)      nxt_state = PAUSE;
        else if (drain_last) nxt_state = DONE;
      end
      PAUSE: begin
        if (pause_rise) nxt_state = RUN;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // After the final word is loaded no further loads occur; the drain counter
  // lets its last bit reach the bottom and be judged before DONE.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int t = 0; t < NUM_TRACKS; t++) begin
        load_reg[t] <= '0;
        fall_reg[t] <= '0;
      end
      phase     <= '0;
      pat_addr  <= '0;
      draining  <= 1'b0;
      drain_cnt <= '0;
    end else if (clear_run) begin
      for (int t = 0; t < NUM_TRACKS; t++) begin
        load_reg[t] <= '0;
        fall_reg[t] <= '0;
      end
      phase     <= '0;
      pat_addr  <= '0;
      draining  <= 1'b0;
      drain_cnt <= '0;
    end else if (step) begin
      for (int t = 0; t < NUM_TRACKS; t++) begin
        fall_reg[t] <= (fall_reg[t] << 1) | FALL_DEPTH'(load_reg[t][PATTERN_BITS-1]);
        if (load_now) load_reg[t] <= pat_data[t*PATTERN_BITS +: PATTERN_BITS];
        else          load_reg[t] <= load_reg[t] << 1;
      end
      phase <= (phase == LAST_PHASE) ? '0 : phase + PH_W'(1);
      if (load_now) begin
        if (pat_addr == end_addr) begin
          draining  <= 1'b1;
          drain_cnt <= DRAIN_STEPS;
        end else begin
          pat_addr <= pat_addr + ADDR_W'(1);
        end
      end else if (draining && drain_cnt != '0) begin
        drain_cnt <= drain_cnt - DR_W'(1);
      end
    end
  end

  always_comb begin
    lane_bot = '0;
    for (int t = 0; t < NUM_TRACKS; t++) lane_bot[t] = fall_reg[t][FALL_DEPTH-1];
  end

  // Judging sees lane_bot and press before this step's shift takes effect.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      score_bcd <= '0;
      streak    <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      if (clear_run) begin
        score_bcd <= '0;
        streak    <= '0;
      end else if (step) begin
        if (press == lane_bot && lane_bot != '0) begin
          hit       <= 1'b1;
          score_bcd <= bcd_inc(score_bcd);
          streak    <= (streak == 8'hFF) ? streak : streak + 8'd1;
        end else if (press != lane_bot) begin
          miss   <= 1'b1;
          streak <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_note_lane_engine.sv
// Self-checking bench for note_lane_engine: directed load/hit/pause/end/reset sequences plus
// randomized songs and presses, judged against an arithmetic note-timing model.
module tb_note_lane_engine;

  localparam int NT = 4;
  localparam int PB = 4;
  localparam int FD = 4;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset_n, tick, start, pause;
  logic [AW-1:0] end_addr, pat_addr;
  logic [NT-1:0] key_n, lane_bot;
  logic [15:0]   pat_data, score_bcd;
  logic [7:0]    streak;
  logic          hit, miss;
  logic [1:0]    state;

  logic          tick2, start2;
  logic [AW-1:0] end_addr2, pat_addr2;
  logic [NT-1:0] key2_n, lane_bot2;
  logic [15:0]   pat_data2;
  logic [7:0]    score_bcd2, streak2;
  logic          hit2, miss2;
  logic [1:0]    state2;

  logic [15:0] song [0:127];
  int checks = 0;
  int errors = 0;
  int step_n, hits_m, streak_m, end_m;

  always #5 clk = ~clk;

  // Behaves as a 1-cycle-latency synchronous pattern RAM.
  always @(posedge clk) pat_data <= song[pat_addr];

  note_lane_engine dut (
    .CLOCK_50(clk), .reset_n(reset_n), .tick(tick), .start(start), .pause(pause),
    .end_addr(end_addr), .key_n(key_n), .pat_addr(pat_addr), .pat_data(pat_data),
    .lane_bot(lane_bot), .score_bcd(score_bcd), .streak(streak), .hit(hit), .miss(miss),
    .state(state)
  );

  note_lane_engine #(.SCORE_DIGITS(2)) dut2 (
    .CLOCK_50(clk), .reset_n(reset_n), .tick(tick2), .start(start2), .pause(1'b0),
    .end_addr(end_addr2), .key_n(key2_n), .pat_addr(pat_addr2), .pat_data(pat_data2),
    .lane_bot(lane_bot2), .score_bcd(score_bcd2), .streak(streak2), .hit(hit2), .miss(miss2),
    .state(state2)
  );

  // Note judged on step s: word w's j-th bit (MSB first) arrives PB+FD+1 steps after start of word.
  function automatic logic [NT-1:0] exp_bot(input int s);
    logic [NT-1:0] r;
    logic [15:0]   word;
    int m, w, j;
    r = '0;
    m = s - (PB + FD + 1);
    if (m >= 0) begin
      w = m / PB;
      j = m % PB;
      if (w <= end_m) begin
        word = song[w];
        for (int t = 0; t < NT; t++) r[t] = word[t*PB + (PB - 1 - j)];
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v, input int digits);
    logic [15:0] r;
    int cap, x;
    cap = 1;
    for (int i = 0; i < digits; i++) cap = cap * 10;
    x = (v > cap - 1) ? cap - 1 : v;
    r = '0;
    for (int i = 0; i < digits; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [NT-1:0] rand_press(input logic [NT-1:0] note);
    int sel;
    sel = $urandom_range(0, 3);
    if (sel <= 1)      return note;
    else if (sel == 2) return NT'($urandom);
    else               return '0;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [NT-1:0] press);
    logic [NT-1:0] note;
    logic          exp_hit, exp_miss;
    int            exp_addr;
    @(negedge clk);
    key_n = ~press;
    repeat (3) @(negedge clk);
    note = exp_bot(step_n + 1);
    checkOutput("lane_bot", 16'(lane_bot), 16'(note));
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    step_n++;
    exp_hit  = (press == note) && (note != '0);
    exp_miss = (press != note);
    if (exp_hit) begin
      hits_m++;
      streak_m = (streak_m >= 255) ? 255 : streak_m + 1;
    end
    if (exp_miss) streak_m = 0;
    exp_addr = (step_n / PB > end_m) ? end_m : step_n / PB;
    checkOutput("hit", 16'(hit), 16'(exp_hit));
    checkOutput("miss", 16'(miss), 16'(exp_miss));
    checkOutput("score", score_bcd, to_bcd(hits_m, 4));
    checkOutput("streak", 16'(streak), 16'(streak_m));
    checkOutput("pat_addr", 16'(pat_addr), 16'(exp_addr));
    checkOutput("state", 16'(state), (step_n >= PB*(end_m+1) + FD + PB) ? 16'd3 : 16'd1);
  endtask

  task automatic startRun(input logic with_pause);
    @(negedge clk);
    start = 1'b1;
    pause = with_pause;
    @(negedge clk);
    start = 1'b0;
    pause = 1'b0;
    step_n   = 0;
    hits_m   = 0;
    streak_m = 0;
    checkOutput("start_state", 16'(state), 16'd1);
    checkOutput("start_score", score_bcd, 16'd0);
    checkOutput("start_streak", 16'(streak), 16'd0);
    checkOutput("start_addr", 16'(pat_addr), 16'd0);
  endtask

  task automatic pauseCheck();
    logic [NT-1:0] note;
    int exp_addr;
    note     = exp_bot(step_n + 1);
    exp_addr = (step_n / PB > end_m) ? end_m : step_n / PB;
    @(negedge clk);
    pause = 1'b1;
    tick  = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checkOutput("pause_enter", 16'(state), 16'd2);
    repeat (20) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
    end
    checkOutput("pause_lane", 16'(lane_bot), 16'(note));
    checkOutput("pause_addr", 16'(pat_addr), 16'(exp_addr));
    checkOutput("pause_score", score_bcd, to_bcd(hits_m, 4));
    checkOutput("pause_streak", 16'(streak), 16'(streak_m));
    checkOutput("pause_state", 16'(state), 16'd2);
    pause = 1'b0;
    @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    checkOutput("pause_resume", 16'(state), 16'd1);
  endtask

  task automatic run2(input int n);
    tick2 = 1'b1;
    repeat (n) @(negedge clk);
    tick2 = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; tick = 1'b0; start = 1'b0; pause = 1'b0;
    key_n = '1; end_addr = '0;
    tick2 = 1'b0; start2 = 1'b0; key2_n = '0; end_addr2 = 7'd127; pat_data2 = 16'hFFFF;
    end_m = 0; step_n = 0; hits_m = 0; streak_m = 0;
    for (int i = 0; i < 128; i++) song[i] = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_state", 16'(state), 16'd0);
    checkOutput("rst_score", score_bcd, 16'd0);
    checkOutput("rst_lane", 16'(lane_bot), 16'd0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed load/fall, hit and miss");
    song[0] = 16'h0808;
    song[1] = 16'h0808;
    end_addr = 7'd1;
    end_m = 1;
    startRun(1'b1);
    for (int s = 1; s <= 8; s++) applyStimulus(4'b0000);
    applyStimulus(4'b0101);
    @(negedge clk);
    checkOutput("hit_pulse_width", 16'(hit), 16'd0);
    for (int s = 10; s <= 12; s++) applyStimulus(4'b0000);
    applyStimulus(4'b0001);
    for (int s = 14; s <= 16; s++) applyStimulus(4'b0000);

    $display("[TB] random song with pause, end_addr=2");
    for (int i = 0; i <= 2; i++) song[i] = 16'($urandom);
    end_addr = 7'd2;
    end_m = 2;
    startRun(1'b0);
    for (int s = 1; s <= 20; s++) begin
      if (s == 6) pauseCheck();
      applyStimulus(rand_press(exp_bot(step_n + 1)));
    end

    $display("[TB] restart from DONE and async reset mid-song");
    for (int i = 0; i <= 6; i++) song[i] = 16'($urandom) | 16'h8888;
    end_addr = 7'd6;
    end_m = 6;
    startRun(1'b0);
    for (int s = 1; s <= 14; s++) applyStimulus(exp_bot(step_n + 1));
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("arst_state", 16'(state), 16'd0);
    checkOutput("arst_addr", 16'(pat_addr), 16'd0);
    checkOutput("arst_score", score_bcd, 16'd0);
    checkOutput("arst_streak", 16'(streak), 16'd0);
    checkOutput("arst_lane", 16'(lane_bot), 16'd0);
    checkOutput("arst_pulses", 16'({hit, miss}), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] saturation on 2-digit instance");
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    checkOutput("sat_start", 16'(state2), 16'd1);
    run2(105);
    checkOutput("sat_score_97", 16'(score_bcd2), to_bcd(105 - 8, 2));
    checkOutput("sat_streak_97", 16'(streak2), 16'(105 - 8));
    checkOutput("sat_hit", 16'({hit2, miss2}), 16'b10);
    run2(195);
    checkOutput("sat_score_hold", 16'(score_bcd2), to_bcd(300 - 8, 2));
    checkOutput("sat_streak_hold", 16'(streak2), 16'd255);
    checkOutput("sat_lane", 16'(lane_bot2), 16'hF);
    run2(220);
    checkOutput("sat_done", 16'(state2), 16'd3);
    checkOutput("sat_addr", 16'(pat_addr2), 16'd127);
    checkOutput("sat_score_end", 16'(score_bcd2), to_bcd(520 - 8, 2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
